// File: rtl/alu_pkg.sv
// Shared codes for the ALU issue stage: control encodings, decode payload
// and the iterative multiply/divide state enum.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SRLV = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_LUI  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_ORI  = 4'd8,
    ALU_BNE  = 4'd9,
    ALU_RSVD = 4'd10,
    ALU_PASS = 4'd11,
    ALU_ILL  = 4'd15
  } aluctl_e;

  typedef enum logic [2:0] {
    AOP_ADD   = 3'b000,
    AOP_SUB   = 3'b001,
    AOP_RTYPE = 3'b010,
    AOP_SLT   = 3'b011,
    AOP_LUI   = 3'b100,
    AOP_ORI   = 3'b101,
    AOP_BNE   = 3'b110,
    AOP_AND   = 3'b111
  } aluop_e;

  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_HI  = 2'b01,
    SEL_LO  = 2'b10
  } hilo_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  typedef enum logic {
    MD_MULTU = 1'b0,
    MD_DIVU  = 1'b1
  } md_op_e;

  typedef struct packed {
    aluctl_e   aluctl;
    hilo_sel_e hilo_sel;
    logic      illegal;
    logic      md_start;
    md_op_e    md_op;
  } dec_t;

  // Main-control plus funct decode into the execute-stage token payload.
  function automatic dec_t decode(input logic [2:0] aluop, input logic [5:0] funct);
    dec_t d;
    d = '{aluctl: ALU_AND, hilo_sel: SEL_ALU, illegal: 1'b0, md_start: 1'b0, md_op: MD_MULTU};
    case (aluop)
      AOP_ADD: d.aluctl = ALU_ADD;
      AOP_SUB: d.aluctl = ALU_SUB;
      AOP_SLT: d.aluctl = ALU_SLT;
      AOP_LUI: d.aluctl = ALU_LUI;
      AOP_ORI: d.aluctl = ALU_ORI;
      AOP_BNE: d.aluctl = ALU_BNE;
      AOP_RTYPE: begin
        case (funct)
          F_ADD:   d.aluctl = ALU_ADD;
          F_SUB:   d.aluctl = ALU_SUB;
          F_AND:   d.aluctl = ALU_AND;
          F_OR:    d.aluctl = ALU_OR;
          F_SLT:   d.aluctl = ALU_SLT;
          F_SRL:   d.aluctl = ALU_SRL;
          F_SRLV:  d.aluctl = ALU_SRLV;
          F_JR:    d.aluctl = ALU_PASS;
          F_MFHI: begin
            d.aluctl   = ALU_PASS;
            d.hilo_sel = SEL_HI;
          end
          F_MFLO: begin
            d.aluctl   = ALU_PASS;
            d.hilo_sel = SEL_LO;
          end
          F_MULTU: d.md_start = 1'b1;
          F_DIVU: begin
            d.md_start = 1'b1;
            d.md_op    = MD_DIVU;
          end
          default: begin
            d.aluctl  = ALU_ILL;
            d.illegal = 1'b1;
          end
        endcase
      end
      default: d.aluctl = ALU_AND;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_iter.sv
// One-bit-per-cycle unsigned multiply (shift-add) and divide (restoring),
// 32 iterations, owning the architectural HI/LO registers.
module md_iter
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_c_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  w_hi_q, w_hi_d;
  logic [XLEN-1:0]  w_lo_q, w_lo_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_rem;
  logic [XLEN-1:0]  div_diff;
  logic             div_ge;
  logic [XLEN-1:0]  step_hi, step_lo;

  // Single iteration step: {w_hi,w_lo} is the product/remainder:quotient pair.
  always_comb begin
    mul_sum  = {1'b0, w_hi_q} + (w_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = {w_hi_q, w_lo_q[XLEN-1]};
    div_ge   = (div_rem >= {1'b0, opnd_q});
    div_diff = XLEN'(div_rem - {1'b0, opnd_q});
    if (op_q == MD_MULTU) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], w_lo_q[XLEN-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_rem[XLEN-1:0];
      step_lo = {w_lo_q[XLEN-2:0], div_ge};
    end
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    w_hi_d   = w_hi_q;
    w_lo_d   = w_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_c_o = busy_q && (cnt_q == CNT_MAX);
    if (busy_q) begin
      w_hi_d = step_hi;
      w_lo_d = step_lo;
      if (cnt_q == CNT_MAX) begin
        busy_d = 1'b0;
        hi_d   = step_hi;
        lo_d   = step_lo;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op_i;
      opnd_d = (op_i == MD_MULTU) ? a_i : b_i;
      w_hi_d = '0;
      w_lo_d = (op_i == MD_MULTU) ? b_i : a_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= MD_MULTU;
      opnd_q <= '0;
      w_hi_q <= '0;
      w_lo_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      opnd_q <= opnd_d;
      w_hi_q <= w_hi_d;
      w_lo_q <= w_lo_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy_o = busy_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_issue.sv
// ALU control issue stage: decodes ops into a registered valid/ready token
// and sequences iterative MULTU/DIVU through md_iter.
module alu_issue
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      aluop_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [3:0]      ALUctl_o,
  output logic [1:0]      hilo_sel_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o
);

  state_e    state_q, state_d;
  logic      out_valid_q, out_valid_d;
  aluctl_e   aluctl_q, aluctl_d;
  hilo_sel_e hilo_sel_q, hilo_sel_d;
  logic      illegal_q, illegal_d;

  dec_t dec;
  logic accept;
  logic md_start;
  logic md_done_c;

  always_comb dec = decode(aluop_i, funct_i);

  assign in_ready_o = !rst_i && (state_q == IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign md_start   = accept && dec.md_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (md_start) state_d = (dec.md_op == MD_MULTU) ? MUL : DIV;
      MUL, DIV: if (md_done_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Token register: load on a non-MD accept, clear on consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready_i;
    aluctl_d    = aluctl_q;
    hilo_sel_d  = hilo_sel_q;
    illegal_d   = illegal_q;
    if (accept && !dec.md_start) begin
      out_valid_d = 1'b1;
      aluctl_d    = dec.aluctl;
      hilo_sel_d  = dec.hilo_sel;
      illegal_d   = dec.illegal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      aluctl_q    <= ALU_AND;
      hilo_sel_q  <= SEL_ALU;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      aluctl_q    <= aluctl_d;
      hilo_sel_q  <= hilo_sel_d;
      illegal_q   <= illegal_d;
    end
  end

  md_iter u_md_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (md_start),
    .op_i     (dec.md_op),
    .a_i      (rs_data_i),
    .b_i      (rt_data_i),
    .busy_o   (busy_o),
    .done_c_o (md_done_c),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  assign out_valid_o = out_valid_q;
  assign ALUctl_o    = aluctl_q;
  assign hilo_sel_o  = hilo_sel_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode map, token handshake, MULTU/DIVU
// results and latency, and reset abort.
module tb_alu_issue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  aluop_i;
  logic [5:0]  funct_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  ALUctl_o;
  logic [1:0]  hilo_sel_o;
  logic        illegal_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  alu_issue dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .aluop_i     (aluop_i),
    .funct_i     (funct_i),
    .rs_data_i   (rs_data_i),
    .rt_data_i   (rt_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ALUctl_o    (ALUctl_o),
    .hilo_sel_o  (hilo_sel_o),
    .illegal_o   (illegal_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [2:0] aop, input logic [5:0] fn);
    in_valid_i = 1'b1;
    aluop_i    = aop;
    funct_i    = fn;
  endtask

  task automatic chk_tok(input string tag, input logic [3:0] ctl, input logic [1:0] sel,
                         input logic ill);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_ctl"},   64'(ALUctl_o),    64'(ctl));
    chk({tag, "_sel"},   64'(hilo_sel_o),  64'(sel));
    chk({tag, "_ill"},   64'(illegal_o),   64'(ill));
  endtask

  // Issue one MULTU/DIVU and count busy cycles (bounded).
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    offer(3'b010, fn);
    rs_data_i = a;
    rt_data_i = b;
    tick();
    in_valid_i = 1'b0;
    chk({tag, "_busy_start"}, 64'(busy_o), 64'd1);
    chk({tag, "_noready"}, 64'(in_ready_o), 64'd0);
    chk({tag, "_notoken"}, 64'(out_valid_o), 64'd0);
    n = 0;
    while (busy_o && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_cycles"}, 64'(n), 64'd32);
    chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    chk({tag, "_ready_after"}, 64'(in_ready_o), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    aluop_i     = 3'b000;
    funct_i     = 6'h00;
    rs_data_i   = '0;
    rt_data_i   = '0;
    out_ready_i = 1'b1;

    // Reset state
    tick();
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    tick();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_ctl",   64'(ALUctl_o),    64'd0);
    chk("rst_sel",   64'(hilo_sel_o),  64'd0);
    chk("rst_ill",   64'(illegal_o),   64'd0);
    chk("rst_busy",  64'(busy_o),      64'd0);
    chk("rst_hi",    64'(hi_o),        64'd0);
    chk("rst_lo",    64'(lo_o),        64'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready_o), 64'd1);

    // Back-to-back R-type stream with no bubbles
    offer(3'b010, 6'h20); tick(); chk_tok("r_add", 4'd2, 2'd0, 1'b0);
    offer(3'b010, 6'h22); tick(); chk_tok("r_sub", 4'd6, 2'd0, 1'b0);
    offer(3'b010, 6'h2A); tick(); chk_tok("r_slt", 4'd7, 2'd0, 1'b0);

    // Remaining decode map, still streaming
    offer(3'b000, 6'h00); tick(); chk_tok("m_add",  4'd2,  2'd0, 1'b0);
    offer(3'b001, 6'h00); tick(); chk_tok("m_sub",  4'd6,  2'd0, 1'b0);
    offer(3'b011, 6'h00); tick(); chk_tok("m_slt",  4'd7,  2'd0, 1'b0);
    offer(3'b100, 6'h00); tick(); chk_tok("m_lui",  4'd5,  2'd0, 1'b0);
    offer(3'b110, 6'h00); tick(); chk_tok("m_bne",  4'd9,  2'd0, 1'b0);
    offer(3'b111, 6'h20); tick(); chk_tok("m_and",  4'd0,  2'd0, 1'b0);
    offer(3'b010, 6'h24); tick(); chk_tok("r_and",  4'd0,  2'd0, 1'b0);
    offer(3'b010, 6'h25); tick(); chk_tok("r_or",   4'd1,  2'd0, 1'b0);
    offer(3'b010, 6'h02); tick(); chk_tok("r_srl",  4'd4,  2'd0, 1'b0);
    offer(3'b010, 6'h06); tick(); chk_tok("r_srlv", 4'd3,  2'd0, 1'b0);
    offer(3'b010, 6'h08); tick(); chk_tok("r_jr",   4'd11, 2'd0, 1'b0);
    offer(3'b010, 6'h10); tick(); chk_tok("r_mfhi", 4'd11, 2'd1, 1'b0);
    offer(3'b010, 6'h12); tick(); chk_tok("r_mflo", 4'd11, 2'd2, 1'b0);
    offer(3'b010, 6'h3F); tick(); chk_tok("r_ill3f", 4'd15, 2'd0, 1'b1);
    offer(3'b010, 6'h00); tick(); chk_tok("r_ill00", 4'd15, 2'd0, 1'b1);
    in_valid_i = 1'b0;
    tick();
    chk("drop_valid", 64'(out_valid_o), 64'd0);

    // ORI stalled by the consumer for three cycles
    out_ready_i = 1'b0;
    offer(3'b101, 6'h00);
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_tok("ori_hold", 4'd8, 2'd0, 1'b0);
      chk("ori_in_ready", 64'(in_ready_o), 64'd0);
      tick();
    end
    chk_tok("ori_4th", 4'd8, 2'd0, 1'b0);
    out_ready_i = 1'b1;
    #1;
    chk("ori_consume_ready", 64'(in_ready_o), 64'd1);
    tick();
    chk("ori_consumed", 64'(out_valid_o), 64'd0);

    // MULTU then MFLO
    run_md("multu", 6'h19, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
    offer(3'b010, 6'h12); tick(); chk_tok("mflo_after", 4'd11, 2'd2, 1'b0);
    in_valid_i = 1'b0;
    tick();

    // DIVU cases, including divide by zero
    run_md("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("divu_5_0",   6'h1B, 32'd5,   32'd0, 32'd5, 32'hFFFF_FFFF);

    // Reset during iteration 10 of a MULTU
    offer(3'b010, 6'h19);
    rs_data_i = 32'd3;
    rt_data_i = 32'd5;
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_busy_pre", 64'(busy_o), 64'd1);
    chk("abort_hi_hold", 64'(hi_o), 64'd5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_o),     64'd0);
    chk("abort_hi",   64'(hi_o),       64'd0);
    chk("abort_lo",   64'(lo_o),       64'd0);
    chk("abort_rdy",  64'(in_ready_o), 64'd1);
    tick();
    chk("abort_stay_idle", 64'(busy_o), 64'd0);
    run_md("multu_3_5", 6'h19, 32'd3, 32'd5, 32'd0, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk_i  in  1  rising-edge clock.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 in_valid_i  in  1  decode-stage op offered.
REQ-005 in_ready_o  out  1  block accepts op this cycle.
REQ-006 aluop_i  in  3  main-control op: 000 ADD, 001 SUB, 010 RTYPE, 011 SLT, 100 LUI, 101 ORI, 110 BNE, 111 AND.
REQ-007 funct_i  in  6  R-type function field, used only when aluop_i=010.
REQ-008 rs_data_i, rt_data_i  in  32 each  operands for MULTU/DIVU.
REQ-009 out_valid_o  out  1  registered ALU control token valid.
REQ-010 out_ready_i  in  1  execute stage consumes token.
REQ-011 ALUctl_o  out  4  ALU operation code for the execute stage.
REQ-012 hilo_sel_o  out  2  00 ALU result, 01 HI, 10 LO.
REQ-013 illegal_o  out  1  token carries an undefined funct; qualified by out_valid_o.
REQ-014 hi_o, lo_o  out  32 each  HI/LO architectural registers.
REQ-015 busy_o  out  1  iterative MULTU/DIVU in progress.

Function
REQ-016 The decode map SHALL be: ADD->2, SUB->6, SLT->7, LUI->5, ORI->8, BNE->9, AND->0.
REQ-017 The RTYPE map SHALL be: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2A->7, 0x02->4, 0x06->3, 0x08->11; 0x10->11 with hilo_sel 01; 0x12->11 with hilo_sel 10.
REQ-018 Any other funct SHALL produce ALUctl_o=15 and illegal_o=1.
REQ-019 A handshake SHALL occur when in_valid_i and in_ready_o are both high.
REQ-020 in_ready_o SHALL equal (state==IDLE) and (!out_valid_o or out_ready_i).
REQ-021 A non-MD op accepted in cycle N SHALL present its token in cycle N+1.
REQ-022 The token SHALL be held stable while out_valid_o is high and out_ready_i is low.
REQ-023 Back-to-back accepts SHALL sustain one token per cycle while out_ready_i stays high.
REQ-024 out_valid_o SHALL drop the cycle after a consume with no new accept.
REQ-025 funct 0x19 (MULTU) or 0x1B (DIVU) SHALL latch the operands, enter MUL or DIV, raise busy_o the next cycle, and produce no token.
REQ-026 State machine: IDLE->MUL or DIV on an accepted MD op; MUL or DIV->IDLE after exactly 32 iteration cycles.
REQ-027 HI/LO SHALL update on the final iteration edge, with busy_o low in the following cycle.
REQ-028 MULTU SHALL be unsigned shift-add with {HI,LO} = 64-bit product.
REQ-029 DIVU SHALL be unsigned restoring division with LO = quotient and HI = remainder.
REQ-030 A divisor of 0 SHALL complete in 32 cycles with LO=0xFFFFFFFF and HI=dividend.
REQ-031 The iteration counter SHALL be 5 bits, counting 0..31 with no wrap beyond the terminal count.
REQ-032 in_ready_o SHALL stay low throughout MUL/DIV, so MFHI/MFLO stall until HI/LO are final.
REQ-033 A pending token SHALL stay valid during MUL/DIV until consumed.
REQ-034 hi_o/lo_o SHALL change only on MD completion or reset.

Reset
REQ-035 rst_i high at a clock edge SHALL clear: state=IDLE, counter=0, out_valid_o=0, ALUctl_o=0, hilo_sel_o=0, illegal_o=0, busy_o=0, hi_o=0, lo_o=0.
REQ-036 Reset mid-MUL/DIV SHALL abort the operation with HI/LO=0 and no partial result kept.
REQ-037 in_ready_o SHALL be 0 during reset and 1 in the first cycle after reset.

Structure
REQ-038 Package alu_pkg SHALL hold: ALUctl codes 0-11 and 15, aluop codes, funct constants, hilo_sel codes, and the state enum IDLE/MUL/DIV.
REQ-039 The iterative datapath SHALL be one sub-module, md_iter (start, op, a, b -> busy, done, hi, lo); alu_issue SHALL hold the decode, token register and FSM.

Verification
REQ-040 aluop=010 with funct 0x20, 0x22, 0x2A on consecutive cycles, out_ready=1 -> ALUctl 2, 6, 7 in cycles N+1..N+3, no bubbles.
REQ-041 ORI accepted with out_ready=0 for 3 cycles -> ALUctl=8 held, in_ready=0; consumed on the 4th cycle.
REQ-042 MULTU 0xFFFFFFFF x 0x2 -> busy for 32 cycles, then HI=0x00000001, LO=0xFFFFFFFE; a following MFLO -> ALUctl=11, hilo_sel=10.
REQ-043 DIVU 100 / 7 -> LO=14, HI=2; DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
REQ-044 funct 0x3F -> ALUctl=15, illegal_o=1 with out_valid.
REQ-045 rst_i asserted at iteration 10 of MULTU -> next cycle busy=0, HI=LO=0, in_ready=1.
